// File: rtl/spmm_row_feeder.sv
// -----------------------------------------------------------------------------
// spmm_row_feeder
//   Transmit side of the SpMM PE row stream. Walks a CSR-packed H matrix held
//   in two BRAMs: for every node it reads node_info {row_len, num_node, flag},
//   then streams row_len h_data words {val, col_idx} as back-to-back beats.
//   After each streamed row it waits for the PE to signal ready.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start_i             pulse, starts a pass over all rows (only in IDLE)
//   node_info_addrb_o   node_info BRAM read address (current row)
//   node_info_dout_i    {row_len, num_node, flag}, one cycle after address
//   h_data_addrb_o      h_data BRAM read address (driven while streaming)
//   h_data_dout_i       {val, col_idx}, one cycle after address
//   pe_rdy_i            PE has finished accumulating the current row
//   spmm_vld_o          beat valid, col_idx_o/val_o meaningful
//   col_idx_o, val_o    beat payload
//   pe_vld_o            pulse on the first beat of each row
//   row_len_o, num_node_o, src_flag_o   current row header, held
//   busy_o              high whenever not IDLE
//   done_o              one-cycle pulse at end of pass
//   err_o               sticky h_data overrun flag
// -----------------------------------------------------------------------------
module spmm_row_feeder #(
   parameter int DATA_WIDTH        = 8,
   parameter int H_NUM_SPARSE_DATA = 242101,
   parameter int TOTAL_NODES       = 13264,
   parameter int NUM_FEATURE_IN    = 1433,
   parameter int MAX_NODES         = 168,
   localparam int COL_IDX_WIDTH    = $clog2(NUM_FEATURE_IN),
   localparam int ROW_LEN_WIDTH    = $clog2(NUM_FEATURE_IN),
   localparam int NUM_NODE_WIDTH   = $clog2(MAX_NODES),
   localparam int H_DATA_WIDTH     = DATA_WIDTH + COL_IDX_WIDTH,
   localparam int NODE_INFO_WIDTH  = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1,
   localparam int NODE_ADDR_WIDTH  = $clog2(TOTAL_NODES),
   localparam int H_ADDR_WIDTH     = $clog2(H_NUM_SPARSE_DATA)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   output logic [NODE_ADDR_WIDTH-1:0] node_info_addrb_o,
   input  logic [NODE_INFO_WIDTH-1:0] node_info_dout_i,
   output logic [H_ADDR_WIDTH-1:0]    h_data_addrb_o,
   input  logic [H_DATA_WIDTH-1:0]    h_data_dout_i,
   input  logic                       pe_rdy_i,
   output logic                       spmm_vld_o,
   output logic [COL_IDX_WIDTH-1:0]   col_idx_o,
   output logic [DATA_WIDTH-1:0]      val_o,
   output logic                       pe_vld_o,
   output logic [ROW_LEN_WIDTH-1:0]   row_len_o,
   output logic [NUM_NODE_WIDTH-1:0]  num_node_o,
   output logic                       src_flag_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   // The h pointer must be able to hold H_NUM_SPARSE_DATA itself (one past the
   // last word) after a pass that exactly fills the BRAM.
   localparam int H_PTR_WIDTH = $clog2(H_NUM_SPARSE_DATA + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INFO     = 3'd1,
      S_LATCH    = 3'd2,
      S_STREAM   = 3'd3,
      S_WAIT_RDY = 3'd4,
      S_NEXT     = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   state_t                      state_r;
   state_t                      state_nx;
   logic [NODE_ADDR_WIDTH-1:0]  row_r;
   logic [H_PTR_WIDTH-1:0]      h_ptr_r;
   logic [ROW_LEN_WIDTH-1:0]    beat_cnt_r;
   logic [ROW_LEN_WIDTH-1:0]    row_len_r;
   logic [NUM_NODE_WIDTH-1:0]   num_node_r;
   logic                        flag_r;
   logic                        spmm_vld_r;
   logic                        pe_vld_r;
   logic                        err_r;

   logic [ROW_LEN_WIDTH-1:0]    info_row_len_s;
   logic [NUM_NODE_WIDTH-1:0]   info_num_node_s;
   logic                        info_flag_s;
   logic                        overrun_s;
   logic                        last_beat_s;
   logic                        last_row_s;

   assign info_row_len_s  = node_info_dout_i[NODE_INFO_WIDTH-1 -: ROW_LEN_WIDTH];
   assign info_num_node_s = node_info_dout_i[NUM_NODE_WIDTH:1];
   assign info_flag_s     = node_info_dout_i[0];

   // Overrun is judged on the header while it is on the BRAM output, so a row
   // that would run past the end is rejected before any address is issued.
   assign overrun_s   = (32'(h_ptr_r) + 32'(info_row_len_s)) > 32'(H_NUM_SPARSE_DATA);
   assign last_beat_s = (beat_cnt_r == (row_len_r - ROW_LEN_WIDTH'(1)));
   assign last_row_s  = (row_r == NODE_ADDR_WIDTH'(TOTAL_NODES - 1));

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_i) state_nx = S_INFO;
            else         state_nx = S_IDLE;
         end
         S_INFO: state_nx = S_LATCH;
         S_LATCH: begin
            if (info_row_len_s == '0) state_nx = S_NEXT;
            else if (overrun_s)       state_nx = S_DONE;
            else                      state_nx = S_STREAM;
         end
         S_STREAM: begin
            if (last_beat_s) state_nx = S_WAIT_RDY;
            else             state_nx = S_STREAM;
         end
         S_WAIT_RDY: begin
            // The first WAIT_RDY cycle carries the last beat of the row; a
            // ready seen then may belong to the previous row, so it is skipped.
            if (pe_rdy_i && !spmm_vld_r) state_nx = S_NEXT;
            else                         state_nx = S_WAIT_RDY;
         end
         S_NEXT: begin
            if (last_row_s) state_nx = S_DONE;
            else            state_nx = S_INFO;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register, pointers, row header and beat flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         row_r      <= '0;
         h_ptr_r    <= '0;
         beat_cnt_r <= '0;
         row_len_r  <= '0;
         num_node_r <= '0;
         flag_r     <= 1'b0;
         spmm_vld_r <= 1'b0;
         pe_vld_r   <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nx;
         // Address issued in STREAM returns data next cycle: beat valid then.
         spmm_vld_r <= (state_r == S_STREAM);
         pe_vld_r   <= (state_r == S_STREAM) && (beat_cnt_r == '0);
         case (state_r)
            S_IDLE: begin
               if (start_i) begin
                  row_r      <= '0;
                  h_ptr_r    <= '0;
                  beat_cnt_r <= '0;
                  err_r      <= 1'b0;
               end
            end
            S_LATCH: begin
               row_len_r  <= info_row_len_s;
               num_node_r <= info_num_node_s;
               flag_r     <= info_flag_s;
               if ((info_row_len_s != '0) && overrun_s) err_r <= 1'b1;
            end
            S_STREAM: begin
               h_ptr_r <= h_ptr_r + H_PTR_WIDTH'(1);
               if (last_beat_s) beat_cnt_r <= '0;
               else             beat_cnt_r <= beat_cnt_r + ROW_LEN_WIDTH'(1);
            end
            S_NEXT: begin
               if (!last_row_s) row_r <= row_r + NODE_ADDR_WIDTH'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign node_info_addrb_o = row_r;
   // Only drive the pointer while streaming; outside STREAM it may legally
   // sit at H_NUM_SPARSE_DATA, which is not a valid BRAM address.
   assign h_data_addrb_o    = (state_r == S_STREAM) ? h_ptr_r[H_ADDR_WIDTH-1:0] : '0;
   assign spmm_vld_o        = spmm_vld_r;
   assign col_idx_o         = spmm_vld_r ? h_data_dout_i[COL_IDX_WIDTH-1:0] : '0;
   assign val_o             = spmm_vld_r ? h_data_dout_i[H_DATA_WIDTH-1 -: DATA_WIDTH] : '0;
   assign pe_vld_o          = pe_vld_r;
   assign row_len_o         = row_len_r;
   assign num_node_o        = num_node_r;
   assign src_flag_o        = flag_r;
   assign busy_o            = (state_r != S_IDLE);
   assign done_o            = (state_r == S_DONE);
   assign err_o             = err_r;

endmodule
